// File: rtl/elevator_car_ctrl_if.sv
// Request/status bundle between the button-latch stage and the car controller.
//   master : latch stage  - drives latched request vectors, receives clear pulses and status
//   slave  : car controller - consumes request vectors, drives clear pulses and status
// Signals: active_in/out_up/out_down_levels (BW), current_floor (FW),
//          moving_up, moving_down, door_open, clear_in/up/down_levels (BW).
interface elevator_car_ctrl_if #(
  parameter int unsigned BUTTONS_WIDTH = 8
);
  localparam int unsigned FW = (BUTTONS_WIDTH > 1) ? $clog2(BUTTONS_WIDTH) : 1;

  logic [BUTTONS_WIDTH-1:0] active_in_levels;
  logic [BUTTONS_WIDTH-1:0] active_out_up_levels;
  logic [BUTTONS_WIDTH-1:0] active_out_down_levels;
  logic [FW-1:0]            current_floor;
  logic                     moving_up;
  logic                     moving_down;
  logic                     door_open;
  logic [BUTTONS_WIDTH-1:0] clear_in_levels;
  logic [BUTTONS_WIDTH-1:0] clear_up_levels;
  logic [BUTTONS_WIDTH-1:0] clear_down_levels;

  modport master (
    output active_in_levels, active_out_up_levels, active_out_down_levels,
    input  current_floor, moving_up, moving_down, door_open,
    input  clear_in_levels, clear_up_levels, clear_down_levels
  );

  modport slave (
    input  active_in_levels, active_out_up_levels, active_out_down_levels,
    output current_floor, moving_up, moving_down, door_open,
    output clear_in_levels, clear_up_levels, clear_down_levels
  );
endinterface

// File: rtl/elevator_car_ctrl.sv
// Collective (SCAN) elevator car controller fed by a button-latch stage.
// Keeps its travel direction while requests remain ahead, stops at eligible
// floors, opens the door and pulses per-floor clears back to the latch stage.
// Ports: clk, reset (sync, active-high), [emergency_stop], bus (slave modport:
//        request vectors in; floor/motion/door status and clear pulses out).
// Optional feature: define EMERGENCY_STOP_EN to add the emergency_stop input,
// which freezes travel, door timing and trip starts while high.
module elevator_car_ctrl #(
  parameter int unsigned BUTTONS_WIDTH = 8,
  parameter int unsigned TRAVEL_CYCLES = 16,
  parameter int unsigned DOOR_CYCLES   = 32
) (
  input logic clk,
  input logic reset,
`ifdef EMERGENCY_STOP_EN
  input logic emergency_stop,
`endif
  elevator_car_ctrl_if.slave bus
);
  localparam int unsigned BW = BUTTONS_WIDTH;
  localparam int unsigned FW = (BW > 1) ? $clog2(BW) : 1;
  localparam int unsigned TW = $clog2(TRAVEL_CYCLES + 1);
  localparam int unsigned DW = $clog2(DOOR_CYCLES + 1);
  localparam logic [FW-1:0] TOP    = FW'(BW - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_MOVE_UP, ST_MOVE_DOWN, ST_DOOR_OPEN} state_t;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  state_t          state_q, state_d;
  dir_t            dir_q, dir_d;
  logic [FW-1:0]   floor_q, floor_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic [BW-1:0]   clr_in_q, clr_up_q, clr_dn_q;
  logic [BW-1:0]   clr_in_d, clr_up_d, clr_dn_d;
  logic [BW-1:0]   clr_in_p_q, clr_up_p_q, clr_dn_p_q;
  logic [BW-1:0]   prev_in_q, prev_up_q, prev_dn_q;
  logic [BW-1:0]   prev_in_d, prev_up_d, prev_dn_d;
  logic            moving_up_q, moving_down_q, door_q;

  logic            stall;
`ifdef EMERGENCY_STOP_EN
  assign stall = emergency_stop;
`else
  assign stall = 1'b0;
`endif

  // Requests with bits hidden for the two cycles after we pulsed their clear
  logic [BW-1:0] in_e, up_e, dn_e, req_e;
  assign in_e  = bus.active_in_levels       & ~(clr_in_q | clr_in_p_q);
  assign up_e  = bus.active_out_up_levels   & ~(clr_up_q | clr_up_p_q);
  assign dn_e  = bus.active_out_down_levels & ~(clr_dn_q | clr_dn_p_q);
  assign req_e = in_e | up_e | dn_e;

  // Floor under evaluation: the arrival floor while moving, else the current one
  logic [FW-1:0] eval_floor;
  logic          eval_up;
  always_comb begin
    eval_floor = floor_q;
    eval_up    = (dir_q == DIR_UP);
    if (state_q == ST_MOVE_UP) begin
      eval_up    = 1'b1;
      eval_floor = (floor_q == TOP) ? floor_q : floor_q + FW'(1);
    end else if (state_q == ST_MOVE_DOWN) begin
      eval_up    = 1'b0;
      eval_floor = (floor_q == '0) ? floor_q : floor_q - FW'(1);
    end
  end

  // Service eligibility at eval_floor; hall calls against the direction wait
  // unless nothing lies further on that side
  logic          above, below, hit_in, hit_up, hit_dn, hit_any;
  logic          fresh_in, fresh_up, fresh_dn;
  logic [BW-1:0] onehot;
  assign above   = |((req_e >> eval_floor) >> 1);
  assign below   = |(req_e & ((BW'(1) << eval_floor) - BW'(1)));
  assign hit_in  = in_e[eval_floor];
  assign hit_up  = up_e[eval_floor] & (eval_up | ~below);
  assign hit_dn  = dn_e[eval_floor] & (~eval_up | ~above);
  assign hit_any = hit_in | hit_up | hit_dn;
  assign onehot  = BW'(1) << eval_floor;
  assign fresh_in = hit_in & ~prev_in_q[eval_floor];
  assign fresh_up = hit_up & ~prev_up_q[eval_floor];
  assign fresh_dn = hit_dn & ~prev_dn_q[eval_floor];

  // Next-state and registered-output decode
  logic stop_here;
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    floor_d   = floor_q;
    tcnt_d    = tcnt_q;
    dcnt_d    = dcnt_q;
    clr_in_d  = '0;
    clr_up_d  = '0;
    clr_dn_d  = '0;
    stop_here = 1'b0;
    prev_in_d = stall ? prev_in_q : in_e;
    prev_up_d = stall ? prev_up_q : up_e;
    prev_dn_d = stall ? prev_dn_q : dn_e;
    if (!stall) begin
      case (state_q)
        ST_IDLE: begin
          if (hit_any) begin
            stop_here = 1'b1;
          end else if (eval_up ? above : below) begin
            state_d = eval_up ? ST_MOVE_UP : ST_MOVE_DOWN;
            tcnt_d  = '0;
          end else if (eval_up ? below : above) begin
            state_d = eval_up ? ST_MOVE_DOWN : ST_MOVE_UP;
            dir_d   = eval_up ? DIR_DOWN : DIR_UP;
            tcnt_d  = '0;
          end
        end
        ST_MOVE_UP, ST_MOVE_DOWN: begin
          if (tcnt_q == T_LAST) begin
            tcnt_d  = '0;
            floor_d = eval_floor;
            if (hit_any) begin
              stop_here = 1'b1;
            end else if (!(eval_up ? above : below)) begin
              state_d = ST_IDLE;
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
        ST_DOOR_OPEN: begin
          // A fresh press at this floor is served in place and holds the door
          if (fresh_in | fresh_up | fresh_dn) begin
            dcnt_d   = '0;
            clr_in_d = fresh_in ? onehot : '0;
            clr_up_d = fresh_up ? onehot : '0;
            clr_dn_d = fresh_dn ? onehot : '0;
          end else if (dcnt_q == D_LAST) begin
            state_d = ST_IDLE;
          end else begin
            dcnt_d = dcnt_q + DW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (stop_here) begin
        state_d  = ST_DOOR_OPEN;
        dcnt_d   = '0;
        clr_in_d = hit_in ? onehot : '0;
        clr_up_d = hit_up ? onehot : '0;
        clr_dn_d = hit_dn ? onehot : '0;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      dir_q         <= DIR_UP;
      floor_q       <= '0;
      tcnt_q        <= '0;
      dcnt_q        <= '0;
      clr_in_q      <= '0;
      clr_up_q      <= '0;
      clr_dn_q      <= '0;
      clr_in_p_q    <= '0;
      clr_up_p_q    <= '0;
      clr_dn_p_q    <= '0;
      prev_in_q     <= '0;
      prev_up_q     <= '0;
      prev_dn_q     <= '0;
      moving_up_q   <= 1'b0;
      moving_down_q <= 1'b0;
      door_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      floor_q       <= floor_d;
      tcnt_q        <= tcnt_d;
      dcnt_q        <= dcnt_d;
      clr_in_q      <= clr_in_d;
      clr_up_q      <= clr_up_d;
      clr_dn_q      <= clr_dn_d;
      clr_in_p_q    <= clr_in_q;
      clr_up_p_q    <= clr_up_q;
      clr_dn_p_q    <= clr_dn_q;
      prev_in_q     <= prev_in_d;
      prev_up_q     <= prev_up_d;
      prev_dn_q     <= prev_dn_d;
      moving_up_q   <= (state_d == ST_MOVE_UP);
      moving_down_q <= (state_d == ST_MOVE_DOWN);
      door_q        <= (state_d == ST_DOOR_OPEN);
    end
  end

  assign bus.current_floor     = floor_q;
  assign bus.moving_up         = moving_up_q;
  assign bus.moving_down       = moving_down_q;
  assign bus.door_open         = door_q;
  assign bus.clear_in_levels   = clr_in_q;
  assign bus.clear_up_levels   = clr_up_q;
  assign bus.clear_down_levels = clr_dn_q;
endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Bench for elevator_car_ctrl: a latch-stage model feeds requests; a floor-level
// SCAN reference model predicts each stop, and a monitor checks every clear pulse.
module tb_elevator_car_ctrl;
  localparam int unsigned BW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  elevator_car_ctrl_if #(.BUTTONS_WIDTH(BW)) bus ();
`ifdef EMERGENCY_STOP_EN
  logic emergency_stop = 1'b0;
`endif

  elevator_car_ctrl #(.BUTTONS_WIDTH(BW), .TRAVEL_CYCLES(16), .DOOR_CYCLES(32)) dut (
    .clk(clk),
    .reset(reset),
`ifdef EMERGENCY_STOP_EN
    .emergency_stop(emergency_stop),
`endif
    .bus(bus)
  );

  // Latch stage: requests stick until a clear pulse is seen at a clock edge
  logic [BW-1:0] lat_in, lat_up, lat_dn;
  logic [BW-1:0] press_in = '0, press_up = '0, press_dn = '0;
  always @(posedge clk) begin
    if (reset) begin
      lat_in <= '0; lat_up <= '0; lat_dn <= '0;
    end else begin
      lat_in <= (lat_in & ~bus.clear_in_levels)   | press_in;
      lat_up <= (lat_up & ~bus.clear_up_levels)   | press_up;
      lat_dn <= (lat_dn & ~bus.clear_down_levels) | press_dn;
    end
  end
  assign bus.active_in_levels       = lat_in;
  assign bus.active_out_up_levels   = lat_up;
  assign bus.active_out_down_levels = lat_dn;

  typedef struct packed {
    logic [7:0] fl;
    logic [7:0] cin;
    logic [7:0] cup;
    logic [7:0] cdn;
  } stop_t;
  stop_t sb[$];

  int total = 0;
  int bad = 0;
  int m_cur = 0;
  bit m_up = 1'b1;

  function automatic stop_t mk(input int f, input int ci, input int cu, input int cd);
    stop_t s;
    s.fl = 8'(f); s.cin = 8'(ci); s.cup = 8'(cu); s.cdn = 8'(cd);
    return s;
  endfunction

  function void check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  // Reference: serve a static request set floor by floor from (m_cur, m_up)
  function automatic bit bit_of(input int v, input int f); return ((v >> f) & 1) != 0; endfunction
  function automatic bit above_of(input int v, input int f); return (v >> (f + 1)) != 0; endfunction
  function automatic bit below_of(input int v, input int f); return (v & ((1 << f) - 1)) != 0; endfunction

  task automatic model_batch(input int i0, input int u0, input int d0);
    int vi, vu, vd, rq, guard;
    bit moving, ci, cu, cd, ab, be;
    vi = i0; vu = u0; vd = d0; moving = 1'b0; guard = 0;
    while (((vi | vu | vd) != 0) && guard < 200) begin
      guard++;
      if (moving) m_cur = m_up ? m_cur + 1 : m_cur - 1;
      rq = vi | vu | vd;
      ab = above_of(rq, m_cur);
      be = below_of(rq, m_cur);
      ci = bit_of(vi, m_cur);
      cu = bit_of(vu, m_cur) && (m_up || !be);
      cd = bit_of(vd, m_cur) && (!m_up || !ab);
      if (ci || cu || cd) begin
        sb.push_back(mk(m_cur, int'(ci) << m_cur, int'(cu) << m_cur, int'(cd) << m_cur));
        vi &= ~(int'(ci) << m_cur);
        vu &= ~(int'(cu) << m_cur);
        vd &= ~(int'(cd) << m_cur);
        moving = 1'b0;
      end else if (m_up ? ab : be) begin
        moving = 1'b1;
      end else if (moving) begin
        moving = 1'b0;
      end else if (m_up ? be : ab) begin
        m_up = !m_up;
        moving = 1'b1;
      end else begin
        break;
      end
    end
  endtask

  // Monitor: every clear pulse must match the next predicted stop
  always @(negedge clk) begin
    stop_t e;
    if (!reset) begin
      check("status_exclusive", int'($countones({bus.moving_up, bus.moving_down, bus.door_open}) > 1), 0);
      if ((bus.clear_in_levels | bus.clear_up_levels | bus.clear_down_levels) != '0) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_clear floor=%0d in=0x%0h up=0x%0h down=0x%0h required=none",
                   bus.current_floor, bus.clear_in_levels, bus.clear_up_levels, bus.clear_down_levels);
        end else begin
          e = sb.pop_front();
          check("stop_floor", int'(bus.current_floor), int'(e.fl));
          check("stop_clear_in", int'(bus.clear_in_levels), int'(e.cin));
          check("stop_clear_up", int'(bus.clear_up_levels), int'(e.cup));
          check("stop_clear_down", int'(bus.clear_down_levels), int'(e.cdn));
          check("stop_door_open", int'(bus.door_open), 1);
        end
      end
    end
  end

  task automatic press(input logic [BW-1:0] i, input logic [BW-1:0] u, input logic [BW-1:0] d);
    @(negedge clk);
    press_in = i; press_up = u; press_dn = d;
    @(negedge clk);
    press_in = '0; press_up = '0; press_dn = '0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sb.size() == 0 && lat_in == '0 && lat_up == '0 && lat_dn == '0 &&
                 !bus.door_open && !bus.moving_up && !bus.moving_down) && n < budget);
    check({tag, "_settle_timeout"}, int'(n >= budget), 0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_floor"}, int'(bus.current_floor), 0);
    check({tag, "_motion_door"}, int'({bus.moving_up, bus.moving_down, bus.door_open}), 0);
    check({tag, "_clears"}, int'(bus.clear_in_levels | bus.clear_up_levels | bus.clear_down_levels), 0);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sb.delete();
    m_cur = 0; m_up = 1'b1;
  endtask

  initial begin
    int n, g;
    logic [BW-1:0] ri, ru, rd;

    // Reset with no requests: stays parked at floor 0
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check_quiet("reset_idle");

    // Single in-car call to floor 3: 48 cycles travel, 32 cycles door
    model_batch(8'h08, 0, 0);
    press(8'h08, '0, '0);
    n = 0; g = 0;
    while (!bus.door_open && g < 200) begin @(negedge clk); g++; if (bus.moving_up) n++; end
    check("t2_move_cycles", n, 48);
    check("t2_floor", int'(bus.current_floor), 3);
    n = 0; g = 0;
    while (bus.door_open && g < 200) begin n++; @(negedge clk); g++; end
    check("t2_door_cycles", n, 32);
    wait_idle("t2", 500);

    // Hall-down at 2 appears while passing 1 upward toward in-car 5
    do_reset();
    press(8'h20, '0, '0);
    g = 0;
    while (!(bus.moving_up && bus.current_floor == 3'd1) && g < 200) begin @(negedge clk); g++; end
    check("t3_reach_floor1_timeout", int'(g >= 200), 0);
    sb.push_back(mk(5, 8'h20, 0, 0));
    sb.push_back(mk(2, 0, 0, 8'h04));
    press('0, '0, 8'h04);
    wait_idle("t3", 1000);
    check("t3_final_floor", int'(bus.current_floor), 2);
    m_cur = 2; m_up = 1'b0;

    // Re-press at the open floor: extra pulse and a full door restart
    model_batch(8'h04, 0, 0);
    press(8'h04, '0, '0);
    g = 0;
    while (!bus.door_open && g < 50) begin @(negedge clk); g++; end
    check("t4_door_timeout", int'(g >= 50), 0);
    repeat (10) @(negedge clk);
    sb.push_back(mk(2, 8'h04, 0, 0));
    press(8'h04, '0, '0);
    n = 0; g = 0;
    do begin @(negedge clk); g++; if (bus.door_open) n++; end while (bus.door_open && g < 100);
    check("t4_door_after_repress", n, 32);
    wait_idle("t4", 200);

    // Reset while travelling 2 -> 3
    press(8'h40, '0, '0);
    g = 0;
    while (!bus.moving_up && g < 50) begin @(negedge clk); g++; end
    repeat (8) @(negedge clk);
    check("t5_floor_before_reset", int'(bus.current_floor), 2);
    reset = 1'b1;
    @(negedge clk);
    check_quiet("t5_after_reset");
    reset = 1'b0;
    sb.delete();
    m_cur = 0; m_up = 1'b1;
    repeat (40) @(negedge clk);
    check_quiet("t5_stays_idle");

    // Random request sets served by the SCAN model
    for (int b = 0; b < 15; b++) begin
      ri = BW'($urandom & $urandom);
      ru = BW'($urandom & $urandom & $urandom);
      rd = BW'($urandom & $urandom & $urandom);
      model_batch(int'(ri), int'(ru), int'(rd));
      press(ri, ru, rd);
      wait_idle("rand", 8000);
      check("rand_final_floor", int'(bus.current_floor), m_cur);
    end

`ifdef EMERGENCY_STOP_EN
    // A 10-cycle emergency hold mid-travel delays arrival by exactly 10 cycles
    do_reset();
    model_batch(8'h02, 0, 0);
    press(8'h02, '0, '0);
    n = 0; g = 0;
    while (!bus.door_open && g < 300) begin
      @(negedge clk); g++;
      if (bus.moving_up) n++;
      emergency_stop = (n >= 5 && n < 15);
    end
    emergency_stop = 1'b0;
    check("estop_move_cycles", n, 26);
    wait_idle("estop", 300);
`endif

    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
